// File: rtl/timer_bus_master.sv
// -----------------------------------------------------------------------------
// timer_bus_master
//
// Initiator-side adapter between the memory unit's load/store path and the
// memory-mapped timer register file. One 32-bit request is accepted at a time
// over a valid/ready handshake. Only aligned word accesses reach the timer;
// anything else is answered with an access fault and no timer access.
// All outputs are registered.
//
// Optional feature macro: TIMER_CONSISTENT_READ_EN
//   When defined, a load of TMR_LO reads HI/LO/HI until both HI samples agree.
//   The matching HI word is kept in a shadow register, and the next TMR_HI load
//   returns it without touching the timer. This gives tear-free 64-bit reads.
//
// Ports:
//   clk_i, rst_n_i                         clock, async active-low reset
//   req_valid_i / req_ready_o              request handshake (ready only in IDLE)
//   req_write_i, req_address_i[3:0]        store flag, byte offset ([3:2] = index)
//   req_width_i[1:0], req_data_i[31:0]     access width (2 = word), store data
//   rsp_valid_o / rsp_ready_i              response handshake
//   rsp_data_o[31:0], rsp_error_o          load data, access fault
//   tmr_write_o, tmr_write_address_o[1:0],
//   tmr_write_data_o[31:0]                 timer write port
//   tmr_read_address_o[1:0],
//   tmr_read_data_i[31:0]                  timer combinational read port
// -----------------------------------------------------------------------------
module timer_bus_master (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [3:0]  req_address_i,
    input  logic [1:0]  req_width_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_error_o,
    output logic        tmr_write_o,
    output logic [1:0]  tmr_write_address_o,
    output logic [31:0] tmr_write_data_o,
    output logic [1:0]  tmr_read_address_o,
    input  logic [31:0] tmr_read_data_i
);

    localparam logic [1:0] IDX_TMR_LO = 2'd2;
    localparam logic [1:0] IDX_TMR_HI = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESPOND
`ifdef TIMER_CONSISTENT_READ_EN
        ,
        RD_HI0,
        RD_LO,
        RD_HI1
`endif
    } state_t;

    state_t state;

`ifdef TIMER_CONSISTENT_READ_EN
    logic [31:0] hi0;
    logic [31:0] shadow_hi;
    logic        shadow_valid;
    logic        use_shadow;
`endif

    // Outputs are registered and are set on the transition into the state
    // that owns them. The timer read port is combinational, so the read
    // address is presented one state ahead of the state that samples it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= IDLE;
            req_ready_o         <= 1'b1;
            rsp_valid_o         <= 1'b0;
            rsp_data_o          <= 32'd0;
            rsp_error_o         <= 1'b0;
            tmr_write_o         <= 1'b0;
            tmr_write_address_o <= 2'd0;
            tmr_write_data_o    <= 32'd0;
            tmr_read_address_o  <= 2'd0;
`ifdef TIMER_CONSISTENT_READ_EN
            hi0                 <= 32'd0;
            shadow_hi           <= 32'd0;
            shadow_valid        <= 1'b0;
            use_shadow          <= 1'b0;
`endif
        end else begin
            // The write strobe lives for the single WRITE cycle only.
            tmr_write_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
`ifdef TIMER_CONSISTENT_READ_EN
                        // Any store may change the timer, so the shadow
                        // HI word can no longer be trusted.
                        if (req_write_i) begin
                            shadow_valid <= 1'b0;
                        end
`endif
                        if (req_width_i != 2'd2 || req_address_i[1:0] != 2'b00) begin
                            rsp_data_o  <= 32'd0;
                            rsp_error_o <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            state       <= RESPOND;
                        end else if (req_write_i) begin
                            tmr_write_o         <= 1'b1;
                            tmr_write_address_o <= req_address_i[3:2];
                            tmr_write_data_o    <= req_data_i;
                            state               <= WRITE;
                        end else begin
`ifdef TIMER_CONSISTENT_READ_EN
                            if (req_address_i[3:2] == IDX_TMR_LO) begin
                                tmr_read_address_o <= IDX_TMR_HI;
                                state              <= RD_HI0;
                            end else if (req_address_i[3:2] == IDX_TMR_HI && shadow_valid) begin
                                // Served from the shadow; the timer is not read.
                                use_shadow <= 1'b1;
                                state      <= READ;
                            end else begin
                                use_shadow         <= 1'b0;
                                tmr_read_address_o <= req_address_i[3:2];
                                state              <= READ;
                            end
`else
                            tmr_read_address_o <= req_address_i[3:2];
                            state              <= READ;
`endif
                        end
                    end
                end

                WRITE: begin
                    rsp_data_o  <= 32'd0;
                    rsp_error_o <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    state       <= RESPOND;
                end

                READ: begin
`ifdef TIMER_CONSISTENT_READ_EN
                    if (use_shadow) begin
                        rsp_data_o   <= shadow_hi;
                        shadow_valid <= 1'b0;
                        use_shadow   <= 1'b0;
                    end else begin
                        rsp_data_o <= tmr_read_data_i;
                    end
`else
                    rsp_data_o <= tmr_read_data_i;
`endif
                    rsp_error_o <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    state       <= RESPOND;
                end

`ifdef TIMER_CONSISTENT_READ_EN
                RD_HI0: begin
                    hi0                <= tmr_read_data_i;
                    tmr_read_address_o <= IDX_TMR_LO;
                    state              <= RD_LO;
                end

                RD_LO: begin
                    // The LO sample goes straight into the response register.
                    // rsp_valid_o is low here, so nobody observes the change.
                    rsp_data_o         <= tmr_read_data_i;
                    tmr_read_address_o <= IDX_TMR_HI;
                    state              <= RD_HI1;
                end

                RD_HI1: begin
                    if (tmr_read_data_i == hi0) begin
                        shadow_hi    <= tmr_read_data_i;
                        shadow_valid <= 1'b1;
                        rsp_error_o  <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        state        <= RESPOND;
                    end else begin
                        // HI rolled over between the samples; retry with the
                        // newer HI as the reference.
                        hi0                <= tmr_read_data_i;
                        tmr_read_address_o <= IDX_TMR_LO;
                        state              <= RD_LO;
                    end
                end
`endif

                RESPOND: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bus_master.sv
// -----------------------------------------------------------------------------
// tb_timer_bus_master
//
// Self-checking bench for timer_bus_master. It contains a behavioural timer
// register file on the DUT's timer ports: two compare words plus a 64-bit
// counter. The counter can be preloaded, and it can be frozen or free-running.
// A transaction-level reference model predicts each response: its latency,
// data and error flag, and the timer write it should cause. The stimulus is
// directed steps followed by a randomized sequence. Steps that need the
// consistent-read feature are guarded by TIMER_CONSISTENT_READ_EN.
// -----------------------------------------------------------------------------
module tb_timer_bus_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [3:0]  req_address_i;
    logic [1:0]  req_width_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;
    logic        tmr_write_o;
    logic [1:0]  tmr_write_address_o;
    logic [31:0] tmr_write_data_o;
    logic [1:0]  tmr_read_address_o;
    logic [31:0] tmr_read_data_i;

    timer_bus_master dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_write_i         (req_write_i),
        .req_address_i       (req_address_i),
        .req_width_i         (req_width_i),
        .req_data_i          (req_data_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_data_o          (rsp_data_o),
        .rsp_error_o         (rsp_error_o),
        .tmr_write_o         (tmr_write_o),
        .tmr_write_address_o (tmr_write_address_o),
        .tmr_write_data_o    (tmr_write_data_o),
        .tmr_read_address_o  (tmr_read_address_o),
        .tmr_read_data_i     (tmr_read_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Timer register file model: index 0/1 compare words, 2/3 counter halves.
    logic [31:0] cmp_reg [2] = '{32'd0, 32'd0};
    logic [63:0] tmr_count = 64'd0;
    bit          tmr_run = 1'b0;
    bit          tmr_load_en = 1'b0;
    logic [63:0] tmr_load_val = 64'd0;

    always @(posedge clk_i) begin
        if (tmr_load_en) begin
            tmr_count <= tmr_load_val;
        end else if (tmr_write_o) begin
            case (tmr_write_address_o)
                2'd0:    cmp_reg[0] <= tmr_write_data_o;
                2'd1:    cmp_reg[1] <= tmr_write_data_o;
                2'd2:    tmr_count[31:0] <= tmr_write_data_o;
                default: tmr_count[63:32] <= tmr_write_data_o;
            endcase
        end else if (tmr_run) begin
            tmr_count <= tmr_count + 64'd1;
        end
    end

    assign tmr_read_data_i = (tmr_read_address_o == 2'd0) ? cmp_reg[0] :
                             (tmr_read_address_o == 2'd1) ? cmp_reg[1] :
                             (tmr_read_address_o == 2'd2) ? tmr_count[31:0] :
                                                            tmr_count[63:32];

`ifdef TIMER_CONSISTENT_READ_EN
    localparam bit CONSISTENT_EN = 1'b1;
`else
    localparam bit CONSISTENT_EN = 1'b0;
`endif

    // Reference model state (frozen-timer view of the register file).
    logic [31:0] ref_regs [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    bit          ref_shadow_valid = 1'b0;
    logic [31:0] ref_shadow_hi = 32'd0;

    int          exp_latency;
    logic [31:0] exp_data;
    logic        exp_error;
    int          exp_wcount;
    logic [1:0]  exp_waddr;
    logic [31:0] exp_wdata;

    int          obs_latency;
    logic [31:0] obs_data;
    logic        obs_error;
    int          obs_wcount;
    int          obs_wcycle;
    logic [1:0]  obs_waddr;
    logic [31:0] obs_wdata;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        checkOutput({tag, "_rsp_data"}, rsp_data_o, 32'd0);
        checkOutput({tag, "_rsp_error"}, 32'(rsp_error_o), 32'd0);
        checkOutput({tag, "_tmr_write"}, 32'(tmr_write_o), 32'd0);
        checkOutput({tag, "_wr_addr"}, 32'(tmr_write_address_o), 32'd0);
        checkOutput({tag, "_wr_data"}, tmr_write_data_o, 32'd0);
        checkOutput({tag, "_rd_addr"}, 32'(tmr_read_address_o), 32'd0);
    endtask

    // Transaction-level prediction from the access rules; updates the model.
    task automatic predict(input logic w, input logic [3:0] a, input logic [1:0] wd,
                           input logic [31:0] d);
        logic [1:0] idx;
        idx = a[3:2];
        exp_wcount = 0;
        exp_waddr = 2'd0;
        exp_wdata = 32'd0;
        exp_error = 1'b0;
        exp_data = 32'd0;
        exp_latency = 2;
        if (w) ref_shadow_valid = 1'b0;
        if (wd != 2'd2 || a[1:0] != 2'b00) begin
            exp_latency = 1;
            exp_error = 1'b1;
        end else if (w) begin
            exp_wcount = 1;
            exp_waddr = idx;
            exp_wdata = d;
            ref_regs[idx] = d;
        end else if (CONSISTENT_EN && idx == 2'd2) begin
            exp_latency = 4;
            exp_data = ref_regs[2];
            ref_shadow_valid = 1'b1;
            ref_shadow_hi = ref_regs[3];
        end else if (CONSISTENT_EN && idx == 2'd3 && ref_shadow_valid) begin
            exp_data = ref_shadow_hi;
            ref_shadow_valid = 1'b0;
        end else begin
            exp_data = ref_regs[idx];
        end
    endtask

    // Issues one request, waits (bounded) for the response, optionally
    // back-pressures it for 'hold' cycles and finally accepts it.
    task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [1:0] wd,
                                 input logic [31:0] d, input int hold, input bit noise);
        checkOutput("req_ready_before", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_address_i = a;
        req_width_i = wd;
        req_data_i = d;
        obs_latency = 99;
        obs_wcount = 0;
        obs_wcycle = 0;
        obs_waddr = 2'd0;
        obs_wdata = 32'd0;
        obs_data = 32'd0;
        obs_error = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (tmr_write_o) begin
                obs_wcount++;
                obs_wcycle = cyc;
                obs_waddr = tmr_write_address_o;
                obs_wdata = tmr_write_data_o;
            end
            if (rsp_valid_o) begin
                obs_latency = cyc;
                break;
            end
            if (noise) begin
                req_valid_i = 1'b1;
                req_write_i = 1'($urandom_range(0, 1));
                req_address_i = 4'($urandom_range(0, 15));
                req_width_i = 2'($urandom_range(0, 3));
                req_data_i = $urandom;
            end
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        if (obs_latency == 99) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
        end else begin
            obs_data = rsp_data_o;
            obs_error = rsp_error_o;
            for (int i = 0; i < hold; i++) begin
                rsp_ready_i = 1'b0;
                @(posedge clk_i); #1;
                checkOutput("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
                checkOutput("hold_rsp_data", rsp_data_o, exp_data);
                checkOutput("hold_rsp_error", 32'(rsp_error_o), 32'(exp_error));
                checkOutput("hold_req_ready", 32'(req_ready_o), 32'd0);
                checkOutput("hold_tmr_write", 32'(tmr_write_o), 32'd0);
            end
            rsp_ready_i = 1'b1;
            @(posedge clk_i); #1;
            rsp_ready_i = 1'b0;
            checkOutput("done_rsp_valid", 32'(rsp_valid_o), 32'd0);
            checkOutput("done_req_ready", 32'(req_ready_o), 32'd1);
        end
    endtask

    task automatic checkTransaction(input string tag);
        checkOutput({tag, "_latency"}, 32'(obs_latency), 32'(exp_latency));
        checkOutput({tag, "_data"}, obs_data, exp_data);
        checkOutput({tag, "_error"}, 32'(obs_error), 32'(exp_error));
        checkOutput({tag, "_wcount"}, 32'(obs_wcount), 32'(exp_wcount));
        if (exp_wcount == 1) begin
            checkOutput({tag, "_wcycle"}, 32'(obs_wcycle), 32'd1);
            checkOutput({tag, "_waddr"}, 32'(obs_waddr), 32'(exp_waddr));
            checkOutput({tag, "_wdata"}, obs_wdata, exp_wdata);
        end
    endtask

    task automatic presetTimer(input logic [63:0] value, input bit run);
        tmr_load_val = value;
        tmr_load_en = 1'b1;
        tmr_run = run;
        @(posedge clk_i); #1;
        tmr_load_en = 1'b0;
    endtask

    task automatic doAccess(input string tag, input logic w, input logic [3:0] a,
                            input logic [1:0] wd, input logic [31:0] d, input int hold);
        predict(w, a, wd, d);
        applyStimulus(w, a, wd, d, hold, 1'b0);
        checkTransaction(tag);
    endtask

    initial begin
        logic       rw;
        logic [3:0] ra;
        logic [1:0] rwd;

        rst_n_i = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_address_i = 4'd0;
        req_width_i = 2'd0;
        req_data_i = 32'd0;
        rsp_ready_i = 1'b0;

        // Reset values, during and after reset.
        repeat (2) @(posedge clk_i);
        #1;
        checkResetValues("in_reset");
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        checkResetValues("after_reset");

        // Store 0x1000 to CMP_LO.
        doAccess("store_cmp_lo", 1'b1, 4'h0, 2'd2, 32'h0000_1000, 0);

        // Set TMR_HI to 7 then load it back.
        doAccess("store_tmr_hi", 1'b1, 4'hC, 2'd2, 32'h0000_0007, 0);
        doAccess("load_tmr_hi", 1'b0, 4'hC, 2'd2, 32'h0, 0);

        // Faults: misaligned, narrow, reserved-width store.
        doAccess("err_misaligned", 1'b0, 4'h2, 2'd2, 32'h0, 0);
        doAccess("err_half", 1'b0, 4'h0, 2'd1, 32'h0, 0);
        doAccess("err_store", 1'b1, 4'h4, 2'd3, 32'hA5A5_A5A5, 0);

        // Back-pressure for 5 cycles on a CMP_LO load.
        doAccess("backpressure", 1'b0, 4'h0, 2'd2, 32'h0, 5);

        // Reset in the WRITE cycle drops the write.
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_address_i = 4'h4;
        req_width_i = 2'd2;
        req_data_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        checkOutput("rst_write_strobe", 32'(tmr_write_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        checkResetValues("mid_reset");
        #3;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        checkResetValues("post_mid_reset");
        ref_shadow_valid = 1'b0;
        doAccess("dropped_write", 1'b0, 4'h4, 2'd2, 32'h0, 0);

`ifdef TIMER_CONSISTENT_READ_EN
        // Running timer crossing a HI boundary during a TMR_LO load.
        presetTimer(64'h0000_0001_FFFF_FFFE, 1'b1);
        exp_latency = 6;
        exp_data = 32'h0000_0002;
        exp_error = 1'b0;
        exp_wcount = 0;
        applyStimulus(1'b0, 4'h8, 2'd2, 32'h0, 0, 1'b0);
        checkTransaction("consistent_lo");
        // Move HI away: the shadow must still return the HI paired with LO.
        presetTimer(64'h0000_0009_0000_0000, 1'b1);
        exp_latency = 2;
        exp_data = 32'h0000_0002;
        applyStimulus(1'b0, 4'hC, 2'd2, 32'h0, 0, 1'b0);
        checkTransaction("shadow_hi");
        exp_data = 32'h0000_0009;
        applyStimulus(1'b0, 4'hC, 2'd2, 32'h0, 0, 1'b0);
        checkTransaction("hi_after_shadow");
`endif

        // Freeze the timer at a known value for the random phase.
        presetTimer(64'h0000_0055_0000_0033, 1'b0);
        ref_regs[2] = 32'h0000_0033;
        ref_regs[3] = 32'h0000_0055;
        ref_shadow_valid = 1'b0;

        for (int n = 0; n < 60; n++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rwd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            req_data_i = $urandom;
            predict(rw, ra, rwd, req_data_i);
            applyStimulus(rw, ra, rwd, req_data_i, $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
            checkTransaction("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_bus_master.md
# timer_bus_master

Initiator-side bus adapter between the memory unit's load/store path and the memory-mapped timer register file. It accepts one 32-bit load or store request at a time over a valid/ready handshake and checks alignment and width. It drives the timer's write port and its combinational read port, and returns a registered response. Optionally, it guarantees tear-free reads of the 64-bit timer value.

## Interface
- No parameters.
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request (IDLE only)
- req_write_i  in  1  1 = store, 0 = load
- req_address_i  in  4  byte offset in timer region; [3:2] = register index (0 CMP_LO, 1 CMP_HI, 2 TMR_LO, 3 TMR_HI)
- req_width_i  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_data_i  in  32  store data
- rsp_valid_o  out  1  response present, held until accepted
- rsp_ready_i  in  1  response consumer ready
- rsp_data_o  out  32  load data (0 for stores and errors)
- rsp_error_o  out  1  access fault (misaligned or non-word)
- tmr_write_o  out  1  timer write strobe
- tmr_write_address_o  out  2  timer write register index
- tmr_write_data_o  out  32  timer write data
- tmr_read_address_o  out  2  timer read register index
- tmr_read_data_i  in  32  timer read data, combinational from tmr_read_address_o

## Operation
- FSM states: IDLE, WRITE, READ, RD_HI0, RD_LO, RD_HI1, RESPOND.
- IDLE:
  - req_ready_o = 1.
  - On handshake, latch write, index, width and data.
  - If req_width_i != 2 or req_address_i[1:0] != 0, go to RESPOND with error = 1 and data = 0. No timer access occurs.
  - Otherwise, a store goes to WRITE.
  - A load goes to READ, or to RD_HI0 when it targets TMR_LO and the macro is defined (see Configuration).
- WRITE:
  - tmr_write_o = 1 for exactly this cycle, with the latched address and data.
  - Next state RESPOND with error = 0 and data = 0.
- READ:
  - tmr_read_address_o = latched index.
  - Sample tmr_read_data_i into the response data register.
  - Next state RESPOND.
- RESPOND:
  - rsp_valid_o = 1; data and error are stable.
  - On rsp_ready_i, go to IDLE.
- tmr_write_o is 0 in every state except WRITE.
- Outside WRITE and the read states, tmr_read_address_o holds its last value.
- Only one request is outstanding at a time. No request is accepted while a response is pending.

## Timing
- Reset values:
  - req_ready_o = 1; rsp_valid_o = 0; rsp_data_o = 0; rsp_error_o = 0.
  - tmr_write_o = 0; tmr_write_address_o = 0; tmr_write_data_o = 0; tmr_read_address_o = 0.
  - Shadow-valid = 0; state = IDLE.
- Request handshake in cycle 0. The response latency to the first cycle of rsp_valid_o is:
  - store: 2 cycles (tmr_write_o in cycle 1);
  - plain load: 2 cycles;
  - error: 1 cycle;
  - consistent load: 4 cycles, plus 2 per retry.
- rsp_ready_i already high in the first RESPOND cycle: response completes in that cycle and req_ready_o = 1 on the next cycle.
- req_valid_i outside IDLE: ignored, with no effect on state.
- Reset asserted mid-transaction: immediately returns to IDLE with all reset values. A pending tmr_write_o is dropped.

## Configuration
- The macro is TIMER_CONSISTENT_READ_EN.
- With TIMER_CONSISTENT_READ_EN defined, a load of TMR_LO runs this sequence:
  - RD_HI0 reads index 3 into hi0.
  - RD_LO reads index 2 into lo.
  - RD_HI1 reads index 3 into hi1.
  - If hi1 == hi0: response data = lo, shadow_hi = hi1, shadow-valid = 1, then RESPOND.
  - Otherwise: hi0 := hi1 and return to RD_LO (retry).
- While the macro is defined, a load of TMR_HI with shadow-valid = 1 returns shadow_hi in 2 cycles without reading the timer.
- Shadow-valid clears after that TMR_HI read.
- Shadow-valid also clears on any accepted store and on reset.
- Without the macro: RD_HI0, RD_LO, RD_HI1 and the shadow logic are absent. Every load uses READ.

## Test plan
- Store 0x0000_1000 to offset 0x0, width 2 -> tmr_write_o high for one cycle at cycle 1, address 0, data 0x1000; rsp_valid_o at cycle 2, error 0, data 0.
- Load offset 0xC with the timer model returning 0x0000_0007 on index 3 -> rsp_data_o = 0x7 at cycle 2 (macro off).
- Load with offset 0x2 or width 1 -> rsp_error_o = 1 and data 0 at cycle 1; tmr_write_o never asserts.
- Macro on, timer value 0x0000_0001_FFFF_FFFF at the RD_HI0 read, counting up by 1 per cycle:
  - a TMR_LO load sees hi0 = 1 and hi1 = 2, so it retries;
  - the retry returns the low word read with hi = 2 (0x0000_0000 plus elapsed cycles);
  - a following TMR_HI load returns 0x0000_0002.
- Hold rsp_ready_i low for 5 cycles -> rsp_valid_o and rsp_data_o stay stable and req_ready_o = 0; assert rsp_ready_i -> req_ready_o = 1 on the next cycle.
- Assert rst_n_i low during WRITE -> tmr_write_o drops immediately, all outputs take their reset values and req_ready_o = 1.
